// File: rtl/axi_init_pkg.sv
// Shared AXI encodings and FSM state type for the RAM init writer.
package axi_init_pkg;
   localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_ADDR,
      S_DATA,
      S_RESP,
      S_DONE
   } state_t;
endpackage

// File: rtl/sync_fifo_64.sv
// Small first-word-fall-through FIFO for 64-bit stream words.
module sync_fifo_64 #(
   parameter int DEPTH = 16,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          clr,
   input  logic          push,
   input  logic [63:0]   wdata,
   input  logic          pop,
   output logic [63:0]   rdata,
   output logic [CW-1:0] count
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [63:0]   mem [DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (clr) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= nxt(wptr);
         if (pop) rptr <= nxt(rptr);
         if (push && !pop) count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   assign rdata = mem[rptr];
endmodule

// File: rtl/axi_ram_init_writer.sv
// AXI4 write-only boot initiator: packs a 64-bit word stream into INCR
// bursts, writes them to on-chip RAM and reports done/error to the core.
module axi_ram_init_writer
   import axi_init_pkg::*;
#(
   parameter int ID_WIDTH   = 6,
   parameter int ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
   parameter int NUM_WORDS  = 8192,
   parameter int BURST_LEN  = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  i_start,
   input  logic [63:0]           i_data,
   input  logic                  i_data_valid,
   output logic                  o_data_ready,
   output logic [ID_WIDTH-1:0]   o_awid,
   output logic [ADDR_WIDTH-1:0] o_awaddr,
   output logic [7:0]            o_awlen,
   output logic [2:0]            o_awsize,
   output logic [1:0]            o_awburst,
   output logic                  o_awvalid,
   input  logic                  i_awready,
   output logic [63:0]           o_wdata,
   output logic [7:0]            o_wstrb,
   output logic                  o_wlast,
   output logic                  o_wvalid,
   input  logic                  i_wready,
   input  logic [ID_WIDTH-1:0]   i_bid,
   input  logic [1:0]            i_bresp,
   input  logic                  i_bvalid,
   output logic                  o_bready,
   output logic                  o_busy,
   output logic                  o_init_done,
   output logic                  o_init_error
);
   localparam int RW = $clog2(NUM_WORDS + 1);
   localparam int CW = $clog2(BURST_LEN + 1);

   state_t                state;
   logic [RW-1:0]         rem;
   logic [RW-1:0]         rem_in;
   logic [ADDR_WIDTH-1:0] addr;
   logic [8:0]            blen_c;
   logic [8:0]            blen_r;
   logic [8:0]            beat;
   logic [CW-1:0]         fifo_count;
   logic                  fifo_full;
   logic                  filling;
   logic                  push;
   logic                  pop;
   logic                  clr;
   logic                  unused_bid;

   assign filling      = state inside {S_FILL, S_ADDR, S_DATA, S_RESP};
   assign fifo_full    = 32'(fifo_count) >= BURST_LEN;
   assign o_data_ready = filling && (rem_in != '0) && !fifo_full;
   assign push         = i_data_valid && o_data_ready;
   assign pop          = o_wvalid && i_wready;
   assign clr          = i_start && (state == S_IDLE || state == S_DONE);

   assign o_awid     = '0;
   assign o_awsize   = AXI_SIZE_8B;
   assign o_awburst  = AXI_BURST_INCR;
   assign o_wstrb    = 8'hFF;
   assign unused_bid = ^i_bid;

   // Final burst shrinks to whatever is still owed.
   always_comb begin
      blen_c = 9'(BURST_LEN);
      if (32'(rem) < BURST_LEN) blen_c = 9'(rem);
   end

   sync_fifo_64 #(.DEPTH(BURST_LEN)) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .clr   (clr),
      .push  (push),
      .wdata (i_data),
      .pop   (pop),
      .rdata (o_wdata),
      .count (fifo_count)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= S_IDLE;
         rem          <= '0;
         rem_in       <= '0;
         addr         <= BASE_ADDR;
         blen_r       <= '0;
         beat         <= '0;
         o_awaddr     <= BASE_ADDR;
         o_awlen      <= '0;
         o_awvalid    <= 1'b0;
         o_wvalid     <= 1'b0;
         o_wlast      <= 1'b0;
         o_bready     <= 1'b0;
         o_busy       <= 1'b0;
         o_init_done  <= 1'b0;
         o_init_error <= 1'b0;
      end else begin
         if (push) rem_in <= rem_in - 1'b1;
         unique case (state)
            S_IDLE, S_DONE: begin
               if (i_start) begin
                  rem          <= RW'(NUM_WORDS);
                  rem_in       <= RW'(NUM_WORDS);
                  addr         <= BASE_ADDR;
                  o_init_done  <= 1'b0;
                  o_init_error <= 1'b0;
                  o_busy       <= 1'b1;
                  state        <= S_FILL;
               end
            end
            S_FILL: begin
               if (9'(fifo_count) >= blen_c) begin
                  o_awaddr  <= addr;
                  o_awlen   <= 8'(blen_c - 9'd1);
                  o_awvalid <= 1'b1;
                  blen_r    <= blen_c;
                  state     <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (i_awready) begin
                  o_awvalid <= 1'b0;
                  o_wvalid  <= 1'b1;
                  o_wlast   <= (blen_r == 9'd1);
                  beat      <= '0;
                  state     <= S_DATA;
               end
            end
            S_DATA: begin
               if (i_wready) begin
                  if (o_wlast) begin
                     o_wvalid <= 1'b0;
                     o_wlast  <= 1'b0;
                     o_bready <= 1'b1;
                     state    <= S_RESP;
                  end else begin
                     beat    <= beat + 9'd1;
                     o_wlast <= (beat + 9'd2 == blen_r);
                  end
               end
            end
            S_RESP: begin
               if (i_bvalid) begin
                  o_bready <= 1'b0;
                  if (i_bresp != AXI_RESP_OKAY) begin
                     o_init_error <= 1'b1;
                     o_init_done  <= 1'b1;
                     o_busy       <= 1'b0;
                     state        <= S_DONE;
                  end else begin
                     addr <= addr + (ADDR_WIDTH'(blen_r) << 3);
                     rem  <= rem - RW'(blen_r);
                     if (32'(rem) == 32'(blen_r)) begin
                        o_init_done <= 1'b1;
                        o_busy      <= 1'b0;
                        state       <= S_DONE;
                     end else begin
                        state <= S_FILL;
                     end
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_ram_init_writer.sv
// Randomized bench: AXI slave + RAM model, stream source and a burst plan
// derived from the word count, checked beat by beat and by RAM readback.
module tb_axi_ram_init_writer;
   localparam int NW  = 20;
   localparam int BL  = 16;
   localparam int IDW = 6;
   localparam int AW  = 32;
   localparam int NB  = (NW + BL - 1) / BL;
   localparam logic [31:0] BASE = 32'h0000_1000;

   logic           clk = 1'b0;
   logic           rstn = 1'b0;
   logic           i_start = 1'b0;
   logic [63:0]    i_data = '0;
   logic           i_data_valid = 1'b0;
   logic           o_data_ready;
   logic [IDW-1:0] o_awid;
   logic [AW-1:0]  o_awaddr;
   logic [7:0]     o_awlen;
   logic [2:0]     o_awsize;
   logic [1:0]     o_awburst;
   logic           o_awvalid;
   logic           i_awready = 1'b0;
   logic [63:0]    o_wdata;
   logic [7:0]     o_wstrb;
   logic           o_wlast;
   logic           o_wvalid;
   logic           i_wready = 1'b0;
   logic [IDW-1:0] i_bid = '0;
   logic [1:0]     i_bresp = 2'b00;
   logic           i_bvalid = 1'b0;
   logic           o_bready;
   logic           o_busy;
   logic           o_init_done;
   logic           o_init_error;

   always #5 clk = ~clk;

   axi_ram_init_writer #(
      .ID_WIDTH   (IDW),
      .ADDR_WIDTH (AW),
      .BASE_ADDR  (BASE),
      .NUM_WORDS  (NW),
      .BURST_LEN  (BL)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .i_start      (i_start),
      .i_data       (i_data),
      .i_data_valid (i_data_valid),
      .o_data_ready (o_data_ready),
      .o_awid       (o_awid),
      .o_awaddr     (o_awaddr),
      .o_awlen      (o_awlen),
      .o_awsize     (o_awsize),
      .o_awburst    (o_awburst),
      .o_awvalid    (o_awvalid),
      .i_awready    (i_awready),
      .o_wdata      (o_wdata),
      .o_wstrb      (o_wstrb),
      .o_wlast      (o_wlast),
      .o_wvalid     (o_wvalid),
      .i_wready     (i_wready),
      .i_bid        (i_bid),
      .i_bresp      (i_bresp),
      .i_bvalid     (i_bvalid),
      .o_bready     (o_bready),
      .o_busy       (o_busy),
      .o_init_done  (o_init_done),
      .o_init_error (o_init_error)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   bit          stall;
   bit          err_first;
   logic [31:0] salt;
   logic [31:0] exp_addr [$];
   logic [7:0]  exp_len [$];
   logic [63:0] mem [logic [31:0]];
   int          src_idx, w_total, aw_cnt, b_cnt, burst_beat, cur_len;
   logic [31:0] cur_addr;
   bit          aw_out, in_burst, bpend, b_hs, push_hs, aw_pend;
   logic [31:0] pend_addr;
   logic [7:0]  pend_len;

   function automatic logic [63:0] word(input int i);
      return {salt, 32'(i) ^ 32'h5A5A_0000};
   endfunction

   // Expected burst sequence straight from word count and burst limit.
   task automatic plan_run();
      salt = $urandom;
      exp_addr.delete();
      exp_len.delete();
      for (int off = 0; off < NW; off += BL) begin
         exp_addr.push_back(BASE + 32'(8 * off));
         exp_len.push_back(8'(((NW - off < BL) ? NW - off : BL) - 1));
      end
      mem.delete();
      src_idx = 0;
      w_total = 0;
      aw_cnt = 0;
      b_cnt = 0;
      burst_beat = 0;
      aw_out = 0;
      in_burst = 0;
      bpend = 0;
   endtask

   always @(negedge clk) begin
      if (!rstn) begin
         i_awready = 0;
         i_wready = 0;
         i_bvalid = 0;
         i_data_valid = 0;
         b_hs = 0;
         push_hs = 0;
         aw_pend = 0;
         in_burst = 0;
         aw_out = 0;
         bpend = 0;
      end else begin
         if (b_hs) i_bvalid = 0;
         if (push_hs) begin
            src_idx++;
            i_data_valid = 0;
         end
         i_awready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
         i_wready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
         if (!i_data_valid)
            i_data_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
         i_data = word(src_idx);
         if (!i_bvalid && bpend && (!stall || $urandom_range(0, 2) == 0)) begin
            i_bvalid = 1;
            i_bresp = (err_first && b_cnt == 0) ? 2'b10 : 2'b00;
            bpend = 0;
         end
         if (aw_pend) begin
            chk("aw_hold_valid", o_awvalid, 1);
            chk("aw_hold_addr", o_awaddr, pend_addr);
            chk("aw_hold_len", o_awlen, pend_len);
         end
         if (in_burst) chk("w_no_gap", o_wvalid, 1);
         b_hs = i_bvalid && o_bready;
         push_hs = i_data_valid && o_data_ready;
         aw_pend = 0;
         if (o_awvalid) begin
            if (i_awready) begin
               chk("aw_single_outstanding", aw_out, 0);
               chk("aw_count_in_run", aw_cnt < NB, 1);
               if (exp_addr.size() > 0) begin
                  chk("awaddr", o_awaddr, exp_addr[0]);
                  chk("awlen", o_awlen, exp_len[0]);
                  cur_len = int'(exp_len.pop_front());
                  void'(exp_addr.pop_front());
               end
               chk("aw_const", {o_awid, o_awsize, o_awburst}, {6'd0, 3'd3, 2'b01});
               cur_addr = o_awaddr;
               aw_out = 1;
               aw_cnt++;
               burst_beat = 0;
            end else begin
               aw_pend = 1;
               pend_addr = o_awaddr;
               pend_len = o_awlen;
            end
         end
         if (o_wvalid && i_wready) begin
            chk("w_after_aw", aw_out && !bpend, 1);
            chk("wdata", o_wdata, word(w_total));
            chk("wlast", o_wlast, burst_beat == cur_len);
            chk("wstrb", o_wstrb, 8'hFF);
            mem[cur_addr + 32'(8 * burst_beat)] = o_wdata;
            w_total++;
            if (o_wlast) begin
               in_burst = 0;
               bpend = 1;
            end else begin
               in_burst = 1;
               burst_beat++;
            end
         end
         if (b_hs) begin
            aw_out = 0;
            b_cnt++;
         end
      end
   end

   task automatic start_pulse(input bit plan);
      @(negedge clk);
      if (plan) plan_run();
      i_start = 1;
      @(negedge clk);
      i_start = 0;
   endtask

   task automatic wait_done();
      for (int k = 0; k < 3000 && !o_init_done; k++) begin
         @(negedge clk);
         #1;
      end
      chk("done_in_time", o_init_done, 1);
   endtask

   task automatic finish_run();
      logic [63:0] v;
      wait_done();
      chk("init_error", o_init_error, 0);
      chk("busy_off", o_busy, 0);
      chk("aw_bursts", aw_cnt, NB);
      chk("w_beats", w_total, NW);
      for (int i = 0; i < NW; i++) begin
         v = 'x;
         if (mem.exists(BASE + 32'(8 * i))) v = mem[BASE + 32'(8 * i)];
         chk("ram_word", v, word(i));
      end
   endtask

   task automatic chk_reset();
      chk("rst_flags", {o_awvalid, o_wvalid, o_bready, o_data_ready, o_busy,
                        o_init_done, o_init_error, o_wlast}, 8'h00);
      chk("rst_awaddr", o_awaddr, BASE);
      chk("rst_awlen", o_awlen, 8'h00);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit hit;
      stall = 0;
      err_first = 0;
      plan_run();
      repeat (3) @(negedge clk);
      chk_reset();
      rstn = 1;
      @(negedge clk);
      #1;
      chk_reset();

      start_pulse(1);
      finish_run();

      stall = 1;
      start_pulse(1);
      for (int k = 0; k < 1000 && aw_cnt < 1; k++) @(negedge clk);
      start_pulse(0);
      #1;
      chk("busy_held", o_busy, 1);
      finish_run();

      for (int r = 0; r < 2; r++) begin
         start_pulse(1);
         finish_run();
      end

      stall = 0;
      err_first = 1;
      start_pulse(1);
      wait_done();
      chk("err_flag", o_init_error, 1);
      chk("err_ready_low", o_data_ready, 0);
      chk("err_busy_low", o_busy, 0);
      repeat (30) @(negedge clk);
      #1;
      chk("err_one_aw", aw_cnt, 1);
      chk("err_sticky", {o_init_done, o_init_error}, 2'b11);
      err_first = 0;

      stall = 1;
      start_pulse(1);
      #1;
      chk("restart_clears", {o_init_done, o_init_error, o_busy}, 3'b001);
      finish_run();

      stall = 0;
      start_pulse(1);
      hit = 0;
      for (int k = 0; k < 400 && !hit; k++) begin
         @(posedge clk);
         #2;
         hit = (burst_beat == 5) && o_wvalid;
      end
      chk("beat5_reached", hit, 1);
      rstn = 0;
      #1;
      chk_reset();
      @(negedge clk);
      @(negedge clk);
      rstn = 1;
      start_pulse(1);
      finish_run();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
